// File: rtl/hex_marquee_scroller.sv
// Scrolling message engine for six active-low seven-segment digits.
// Optional build macro MARQUEE_REVERSE_EN adds a dir input for right scrolling.
module hex_marquee_scroller #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [31:0]   delay,
    input  logic          run,
`ifdef MARQUEE_REVERSE_EN
    input  logic          dir,
`endif
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_seg,
    input  logic          len_wr,
    input  logic [AW:0]   len_val,
    output logic [6:0]    HEX5,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX0,
    output logic          wrap
);

    typedef enum logic [1:0] {EMPTY, HOLD, SCROLL} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] ptr_q, ptr_d;
    logic        wrap_q, wrap_d;
    logic [6:0]  mem_q [DEPTH];
    logic [6:0]  hex_q [6];
    logic [6:0]  hex_d [6];
    logic [AW:0] idx [6];
    logic [AW:0] ptr_nxt;
    logic        tick;
    logic        at_end;

    always_comb begin
        tick = (state_q == SCROLL) && (count_q >= delay);
`ifdef MARQUEE_REVERSE_EN
        if (dir) begin
            at_end  = (ptr_q == '0);
            ptr_nxt = at_end ? len_q - 1'b1 : ptr_q - 1'b1;
        end else begin
            at_end  = (ptr_q == len_q - 1'b1);
            ptr_nxt = at_end ? '0 : ptr_q + 1'b1;
        end
`else
        at_end  = (ptr_q == len_q - 1'b1);
        ptr_nxt = at_end ? '0 : ptr_q + 1'b1;
`endif
        count_d = count_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        // A length load restarts the scroll and masks any coincident tick.
        if (len_wr) begin
            len_d   = (len_val > DEPTH_L) ? DEPTH_L : len_val;
            ptr_d   = '0;
            count_d = '0;
        end else if (state_q == EMPTY) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
            ptr_d   = ptr_nxt;
            wrap_d  = at_end;
        end else if (state_q == SCROLL) begin
            count_d = count_q + 32'd1;
        end
        if (len_d == '0) begin
            state_d = EMPTY;
        end else if (run) begin
            state_d = SCROLL;
        end else begin
            state_d = HOLD;
        end
    end

    // Successive digits walk the buffer circularly, so short messages repeat.
    always_comb begin
        idx[0] = ptr_q;
        for (int k = 1; k < 6; k++) begin
            idx[k] = (idx[k-1] + 1'b1 == len_q) ? '0 : idx[k-1] + 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            hex_d[k] = (len_q == '0) ? 7'h7F : ~mem_q[idx[k][AW-1:0]];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < 6; k++) hex_q[k] <= 7'h7F;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
            if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) mem_q[wr_addr] <= wr_seg;
            for (int k = 0; k < 6; k++) hex_q[k] <= hex_d[k];
        end
    end

    assign HEX5 = hex_q[0];
    assign HEX4 = hex_q[1];
    assign HEX3 = hex_q[2];
    assign HEX2 = hex_q[3];
    assign HEX1 = hex_q[4];
    assign HEX0 = hex_q[5];
    assign wrap = wrap_q;

endmodule
